// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared layer/tile control types for the tile scheduler
package ctrl_pkg;

  localparam int CMD_CH_W  = 11;
  localparam int CMD_DIM_W = 8;
  localparam int CMD_TN_W  = 32;

  typedef enum logic [1:0] {
    POINTWISE = 2'd0,
    DEPTHWISE = 2'd1,
    STANDARD  = 2'd2,
    LINEAR    = 2'd3
  } layer_type_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic [CMD_DIM_W-1:0] row;
    logic [CMD_DIM_W-1:0] row_len;
    logic [CMD_CH_W-1:0]  k;
    logic [CMD_CH_W-1:0]  k_len;
    logic [CMD_CH_W-1:0]  d;
    logic [CMD_CH_W-1:0]  d_len;
    logic                 first_d;
    logic                 last_d;
    logic                 last;
  } tile_cmd_t;

endpackage

// File: rtl/tile_loop_cnt.sv
// rtl/tile_loop_cnt.sv - one tiled loop dimension: index, ragged tile length, last/wrap flags
module tile_loop_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] base,
  input  logic [W-1:0] step,
  input  logic [W-1:0] limit,
  output logic [W-1:0] idx,
  output logic [W-1:0] len,
  output logic         last,
  output logic         wrap
);

  logic [W:0]   sum;
  logic [W-1:0] remain;

  // one extra bit so idx+step near the top of the range cannot alias back below limit
  assign sum    = {1'b0, idx} + {1'b0, step};
  assign last   = (sum >= {1'b0, limit});
  assign wrap   = inc && last;
  assign remain = limit - idx;
  assign len    = (step < remain) ? step : remain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (clr || wrap) begin
      idx <= base;
    end else if (inc) begin
      idx <= sum[W-1:0];
    end
  end

endmodule

// File: rtl/layer_tile_scheduler.sv
// rtl/layer_tile_scheduler.sv - walks row x K x D tile space, one command per tile over valid/ready
// Optional perf counters (transfers, stall cycles) under `define TILE_SCHED_PERF_EN.
module layer_tile_scheduler
  import ctrl_pkg::*;
#(
  parameter int CH_W  = CMD_CH_W,
  parameter int DIM_W = CMD_DIM_W,
  parameter int TN_W  = CMD_TN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [1:0]        layer_type_i,
  input  logic [CH_W-1:0]   in_D_i,
  input  logic [CH_W-1:0]   out_K_i,
  input  logic [DIM_W-1:0]  out_R_i,
  input  logic [DIM_W-1:0]  tile_D_i,
  input  logic [DIM_W-1:0]  tile_K_i,
  input  logic [TN_W-1:0]   tile_n_i,
  output logic              cmd_valid_o,
  input  logic              cmd_ready_i,
  output logic [DIM_W-1:0]  cmd_row_o,
  output logic [DIM_W-1:0]  cmd_row_len_o,
  output logic [CH_W-1:0]   cmd_k_o,
  output logic [CH_W-1:0]   cmd_k_len_o,
  output logic [CH_W-1:0]   cmd_d_o,
  output logic [CH_W-1:0]   cmd_d_len_o,
  output logic              cmd_first_d_o,
  output logic              cmd_last_d_o,
  output logic              cmd_last_o,
`ifdef TILE_SCHED_PERF_EN
  output logic [31:0]       perf_cmd_cnt_o,
  output logic [31:0]       perf_stall_cnt_o,
`endif
  output logic              busy_o,
  output logic              done_o
);

  sched_state_e state, nxt;
  layer_type_e  ltype;
  logic [CH_W-1:0]  in_d, out_k;
  logic [DIM_W-1:0] out_r, rows_ps, t_d, t_k;

  logic accept, valid, xfer, is_dw, empty;
  logic [DIM_W-1:0] rows_ps_in;

  logic [DIM_W-1:0] row_idx, row_len;
  logic [CH_W-1:0]  k_idx, k_len, d_idx, d_len;
  logic row_last, row_wrap, k_last, k_wrap, d_last, d_wrap;
  logic d_adv, d_done;
  tile_cmd_t cmd;

  assign accept = (state == IDLE) && start_i;
  assign valid  = (state == ISSUE);
  assign xfer   = valid && cmd_ready_i;
  assign is_dw  = (ltype == DEPTHWISE);
  assign empty  = (out_r == '0) || (out_k == '0) || ((in_d == '0) && !is_dw);

  assign rows_ps_in = (tile_n_i == '0)                   ? DIM_W'(1) :
                      (tile_n_i < TN_W'(out_R_i))        ? tile_n_i[DIM_W-1:0] :
                                                           out_R_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ltype   <= POINTWISE;
      in_d    <= '0;
      out_k   <= '0;
      out_r   <= '0;
      rows_ps <= '0;
      t_d     <= '0;
      t_k     <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        ltype   <= layer_type_e'(layer_type_i);
        in_d    <= in_D_i;
        out_k   <= out_K_i;
        out_r   <= out_R_i;
        rows_ps <= rows_ps_in;
        t_d     <= (tile_D_i == '0) ? DIM_W'(1) : tile_D_i;
        t_k     <= (tile_K_i == '0) ? DIM_W'(1) : tile_K_i;
      end
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (start_i) nxt = LOAD;
      LOAD:  nxt = empty ? DONE : ISSUE;
      ISSUE: if (row_wrap) nxt = DONE;
      DONE:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // depthwise layers have no D loop: every transfer advances K directly
  assign d_adv  = is_dw ? xfer : d_wrap;
  assign d_done = is_dw || d_last;

  tile_loop_cnt #(.W(DIM_W)) u_row (
    .clk(clk), .rst(rst), .clr(accept), .inc(k_wrap),
    .base('0), .step(rows_ps), .limit(out_r),
    .idx(row_idx), .len(row_len), .last(row_last), .wrap(row_wrap)
  );

  tile_loop_cnt #(.W(CH_W)) u_k (
    .clk(clk), .rst(rst), .clr(accept), .inc(d_adv),
    .base('0), .step(CH_W'(t_k)), .limit(out_k),
    .idx(k_idx), .len(k_len), .last(k_last), .wrap(k_wrap)
  );

  tile_loop_cnt #(.W(CH_W)) u_d (
    .clk(clk), .rst(rst), .clr(accept), .inc(xfer && !is_dw),
    .base('0), .step(CH_W'(t_d)), .limit(in_d),
    .idx(d_idx), .len(d_len), .last(d_last), .wrap(d_wrap)
  );

  always_comb begin
    cmd = '0;
    if (valid) begin
      cmd.row     = row_idx;
      cmd.row_len = row_len;
      cmd.k       = k_idx;
      cmd.k_len   = k_len;
      cmd.d       = is_dw ? k_idx : d_idx;
      cmd.d_len   = is_dw ? k_len : d_len;
      cmd.first_d = is_dw || (d_idx == '0);
      cmd.last_d  = d_done;
      cmd.last    = d_done && k_last && row_last;
    end
  end

  assign cmd_valid_o   = valid;
  assign cmd_row_o     = cmd.row;
  assign cmd_row_len_o = cmd.row_len;
  assign cmd_k_o       = cmd.k;
  assign cmd_k_len_o   = cmd.k_len;
  assign cmd_d_o       = cmd.d;
  assign cmd_d_len_o   = cmd.d_len;
  assign cmd_first_d_o = cmd.first_d;
  assign cmd_last_d_o  = cmd.last_d;
  assign cmd_last_o    = cmd.last;
  assign busy_o        = (state != IDLE);
  assign done_o        = (state == DONE);

`ifdef TILE_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_cmd_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else if (accept) begin
      perf_cmd_cnt_o   <= '0;
      perf_stall_cnt_o <= '0;
    end else begin
      if (xfer && (perf_cmd_cnt_o != '1))
        perf_cmd_cnt_o <= perf_cmd_cnt_o + 32'd1;
      if (valid && !cmd_ready_i && (perf_stall_cnt_o != '1))
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_layer_tile_scheduler.sv
// tb/tb_layer_tile_scheduler.sv - directed self-checking bench for layer_tile_scheduler
module tb_layer_tile_scheduler;

  localparam int CH_W  = 11;
  localparam int DIM_W = 8;
  localparam int TN_W  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start_i = 1'b0;
  logic [1:0]        layer_type_i = '0;
  logic [CH_W-1:0]   in_D_i = '0;
  logic [CH_W-1:0]   out_K_i = '0;
  logic [DIM_W-1:0]  out_R_i = '0;
  logic [DIM_W-1:0]  tile_D_i = '0;
  logic [DIM_W-1:0]  tile_K_i = '0;
  logic [TN_W-1:0]   tile_n_i = '0;
  logic              cmd_ready_i = 1'b1;
  logic              cmd_valid_o;
  logic [DIM_W-1:0]  cmd_row_o, cmd_row_len_o;
  logic [CH_W-1:0]   cmd_k_o, cmd_k_len_o, cmd_d_o, cmd_d_len_o;
  logic              cmd_first_d_o, cmd_last_d_o, cmd_last_o;
  logic              busy_o, done_o;
`ifdef TILE_SCHED_PERF_EN
  logic [31:0]       perf_cmd_cnt_o, perf_stall_cnt_o;
`endif

  int n_pass  = 0;
  int n_total = 0;

  layer_tile_scheduler dut (
    .clk(clk), .rst(rst), .start_i(start_i), .layer_type_i(layer_type_i),
    .in_D_i(in_D_i), .out_K_i(out_K_i), .out_R_i(out_R_i),
    .tile_D_i(tile_D_i), .tile_K_i(tile_K_i), .tile_n_i(tile_n_i),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_row_o(cmd_row_o), .cmd_row_len_o(cmd_row_len_o),
    .cmd_k_o(cmd_k_o), .cmd_k_len_o(cmd_k_len_o),
    .cmd_d_o(cmd_d_o), .cmd_d_len_o(cmd_d_len_o),
    .cmd_first_d_o(cmd_first_d_o), .cmd_last_d_o(cmd_last_d_o), .cmd_last_o(cmd_last_o),
`ifdef TILE_SCHED_PERF_EN
    .perf_cmd_cnt_o(perf_cmd_cnt_o), .perf_stall_cnt_o(perf_stall_cnt_o),
`endif
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic start_layer(input logic [1:0] lt, input int in_d, input int out_k, input int out_r,
                             input int t_d, input int t_k, input int t_n);
    @(posedge clk); #1;
    layer_type_i = lt;
    in_D_i   = CH_W'(in_d);
    out_K_i  = CH_W'(out_k);
    out_R_i  = DIM_W'(out_r);
    tile_D_i = DIM_W'(t_d);
    tile_K_i = DIM_W'(t_k);
    tile_n_i = TN_W'(t_n);
    start_i  = 1'b1;
    @(posedge clk); #1;
    start_i  = 1'b0;
  endtask

  // returns at the falling edge where a handshake is pending; cycles counts falling edges waited
  task automatic wait_xfer(output int cycles, output bit ok);
    cycles = 0;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      cycles++;
      if (cmd_valid_o && cmd_ready_i) ok = 1'b1;
    end
  endtask

  task automatic run_layer(input string name, input logic [1:0] lt, input int in_d, input int out_k,
                           input int out_r, input int t_d, input int t_k, input int t_n, input int exp_n);
    int n, cyc, rps, tke, tde, dlim, dstep;
    bit ok, dw, lastd;
    n   = 0;
    dw  = (lt == 2'd1);
    rps = (t_n == 0) ? 1 : imin(t_n, out_r);
    tke = (t_k == 0) ? 1 : t_k;
    tde = (t_d == 0) ? 1 : t_d;
    dlim  = dw ? 1 : in_d;
    dstep = dw ? 1 : tde;
    start_layer(lt, in_d, out_k, out_r, t_d, t_k, t_n);
    for (int r = 0; r < out_r; r += rps)
      for (int k = 0; k < out_k; k += tke)
        for (int d = 0; d < dlim; d += dstep) begin
          wait_xfer(cyc, ok);
          if (!ok) begin
            check($sformatf("%s timeout", name), 0, 1);
            return;
          end
          n++;
          check($sformatf("%s#%0d gap", name, n), cyc, (n == 1) ? 2 : 1);
          lastd = dw || (d + tde >= in_d);
          check($sformatf("%s#%0d row", name, n), 32'(cmd_row_o), r);
          check($sformatf("%s#%0d row_len", name, n), 32'(cmd_row_len_o), imin(rps, out_r - r));
          check($sformatf("%s#%0d k", name, n), 32'(cmd_k_o), k);
          check($sformatf("%s#%0d k_len", name, n), 32'(cmd_k_len_o), imin(tke, out_k - k));
          check($sformatf("%s#%0d d", name, n), 32'(cmd_d_o), dw ? k : d);
          check($sformatf("%s#%0d d_len", name, n), 32'(cmd_d_len_o),
                dw ? imin(tke, out_k - k) : imin(tde, in_d - d));
          check($sformatf("%s#%0d first_d", name, n), 32'(cmd_first_d_o), 32'(dw || d == 0));
          check($sformatf("%s#%0d last_d", name, n), 32'(cmd_last_d_o), 32'(lastd));
          check($sformatf("%s#%0d last", name, n), 32'(cmd_last_o),
                32'((r + rps >= out_r) && (k + tke >= out_k) && lastd));
        end
    check($sformatf("%s count", name), n, exp_n);
    @(negedge clk);
    check($sformatf("%s done", name), 32'(done_o), 1);
    check($sformatf("%s valid_in_done", name), 32'(cmd_valid_o), 0);
    check($sformatf("%s busy_in_done", name), 32'(busy_o), 1);
`ifdef TILE_SCHED_PERF_EN
    check($sformatf("%s perf_cmd", name), perf_cmd_cnt_o, exp_n);
    check($sformatf("%s perf_stall", name), perf_stall_cnt_o, 0);
`endif
    @(negedge clk);
    check($sformatf("%s done_pulse", name), 32'(done_o), 0);
    check($sformatf("%s idle", name), 32'(busy_o), 0);
  endtask

  initial begin
    int cyc;
    bit ok;

    @(negedge clk);
    check("rst valid", 32'(cmd_valid_o), 0);
    check("rst busy", 32'(busy_o), 0);
    check("rst done", 32'(done_o), 0);
    check("rst k_len", 32'(cmd_k_len_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_layer("pw",   2'd0, 64, 64, 4, 32, 32, 2, 8);
    run_layer("std",  2'd2, 10, 40, 1, 10, 32, 1, 2);
    run_layer("dw",   2'd1, 0,  20, 3, 7,  10, 5, 2);
    run_layer("tn0",  2'd0, 8,  8,  2, 8,  8,  0, 2);
    run_layer("lin",  2'd3, 20, 5,  5, 8,  4,  2, 18);
    run_layer("tk0",  2'd0, 3,  2,  1, 0,  0,  1, 6);

    // backpressure on the second command, with a start pulse that must be ignored while busy
    start_layer(2'd2, 10, 40, 1, 10, 32, 1);
    wait_xfer(cyc, ok);
    check("bp cmd1 ok", 32'(ok), 1);
    check("bp cmd1 k_len", 32'(cmd_k_len_o), 32);
    @(posedge clk); #1;
    cmd_ready_i = 1'b0;
    start_i = 1'b1;
    out_K_i = CH_W'(99);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("bp stall%0d valid", i), 32'(cmd_valid_o), 1);
      check($sformatf("bp stall%0d k", i), 32'(cmd_k_o), 32);
      check($sformatf("bp stall%0d k_len", i), 32'(cmd_k_len_o), 8);
      check($sformatf("bp stall%0d last", i), 32'(cmd_last_o), 1);
      @(posedge clk);
    end
    #1;
    cmd_ready_i = 1'b1;
    start_i = 1'b0;
    wait_xfer(cyc, ok);
    check("bp cmd2 gap", cyc, 1);
    check("bp cmd2 k", 32'(cmd_k_o), 32);
    @(negedge clk);
    check("bp done", 32'(done_o), 1);
`ifdef TILE_SCHED_PERF_EN
    check("bp perf_cmd", perf_cmd_cnt_o, 2);
    check("bp perf_stall", perf_stall_cnt_o, 3);
`endif
    @(negedge clk);
    check("bp idle", 32'(busy_o), 0);

    // empty layer: LOAD then DONE, no command
    start_layer(2'd0, 8, 8, 0, 8, 8, 1);
    @(negedge clk);
    check("empty load busy", 32'(busy_o), 1);
    check("empty load valid", 32'(cmd_valid_o), 0);
    check("empty load done", 32'(done_o), 0);
    @(negedge clk);
    check("empty done", 32'(done_o), 1);
    check("empty valid", 32'(cmd_valid_o), 0);
    @(negedge clk);
    check("empty idle", 32'(busy_o), 0);
    check("empty done_pulse", 32'(done_o), 0);

    // reset mid-layer, then restart cleanly
    start_layer(2'd0, 64, 64, 4, 32, 32, 2);
    wait_xfer(cyc, ok);
    wait_xfer(cyc, ok);
    check("mid cmd2 d", 32'(cmd_d_o), 32);
    #1;
    rst = 1'b1;
    #1;
    check("mid rst valid", 32'(cmd_valid_o), 0);
    check("mid rst busy", 32'(busy_o), 0);
    check("mid rst d", 32'(cmd_d_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post rst done", 32'(done_o), 0);
    run_layer("restart", 2'd0, 64, 64, 4, 32, 32, 2, 8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
